// File: rtl/pool_game_pkg.sv
// Shared types, pocket geometry and per-level ball setup for the
// pool turn controller.
package pool_game_pkg;

    localparam int unsigned DEF_N_HOLES  = 6;
    localparam int unsigned DEF_N_LEVELS = 10;
    localparam int unsigned DEF_COORD_W  = 11;
    localparam int unsigned TBL_HOLE_W   = $clog2(DEF_N_HOLES);

    typedef enum logic [2:0] {
        S_INIT,
        S_LOAD,
        S_ARM,
        S_PLAY,
        S_OVER
    } state_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] red_x;
        logic [DEF_COORD_W-1:0] red_y;
        logic [DEF_COORD_W-1:0] white_x;
        logic [DEF_COORD_W-1:0] white_y;
        logic [TBL_HOLE_W-1:0]  target_hole;
    } level_entry_t;

    // Pockets: three along the top cushion, three along the bottom.
    localparam logic [DEF_COORD_W-1:0] HOLE_X [DEF_N_HOLES] = '{
        11'd40, 11'd320, 11'd600, 11'd40, 11'd320, 11'd600
    };

    localparam logic [DEF_COORD_W-1:0] HOLE_Y [DEF_N_HOLES] = '{
        11'd40, 11'd40, 11'd40, 11'd440, 11'd440, 11'd440
    };

    localparam level_entry_t LEVEL_TABLE [DEF_N_LEVELS] = '{
        '{11'd400, 11'd240, 11'd160, 11'd240, 3'd0},
        '{11'd420, 11'd200, 11'd160, 11'd260, 3'd2},
        '{11'd380, 11'd300, 11'd140, 11'd200, 3'd5},
        '{11'd450, 11'd180, 11'd120, 11'd300, 3'd3},
        '{11'd360, 11'd260, 11'd200, 11'd220, 3'd1},
        '{11'd480, 11'd320, 11'd180, 11'd160, 3'd4},
        '{11'd300, 11'd150, 11'd100, 11'd340, 3'd0},
        '{11'd500, 11'd240, 11'd150, 11'd240, 3'd5},
        '{11'd420, 11'd360, 11'd220, 11'd120, 3'd2},
        '{11'd340, 11'd220, 11'd260, 11'd280, 3'd1}
    };

endpackage

// File: rtl/pool_turn_controller_event_holdoff.sv
// One-cycle event pulse that masks further firing for a number of
// frames after it fires.
module event_holdoff #(
    parameter int unsigned HOLDOFF_FRAMES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic start_of_frame,
    output logic pulse,
    output logic armed
);

    localparam int unsigned CNT_W =
        (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    assign armed = (cnt_q == '0);
    assign pulse = pulse_q;

    // A fresh firing reloads the count even on a frame boundary.
    always_comb begin
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        if (raw && armed) begin
            pulse_d = 1'b1;
            cnt_d   = CNT_W'(HOLDOFF_FRAMES);
        end else if (start_of_frame && !armed) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/pool_turn_controller.sv
// Pool game turn controller: collision levels, debounced events,
// level/turn sequencing, saturating score and per-level setup.
module pool_turn_controller
    import pool_game_pkg::*;
#(
    parameter int unsigned N_HOLES        = DEF_N_HOLES,
    parameter int unsigned N_LEVELS       = DEF_N_LEVELS,
    parameter int unsigned COORD_W        = DEF_COORD_W,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned HOLDOFF_FRAMES = 4,
    localparam int unsigned HOLE_W        = $clog2(N_HOLES),
    localparam int unsigned LEVEL_W       = $clog2(N_LEVELS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_of_frame,
    input  logic               dr_white,
    input  logic               dr_red,
    input  logic [N_HOLES-1:0] dr_hole,
    input  logic               dr_border,
    input  logic               white_stopped,
    input  logic               red_stopped,
    input  logic               white_started,
    input  logic               restart,
    output logic               collision,
    output logic               single_hit_pulse,
    output logic               hit_white_red,
    output logic               pot_red,
    output logic               pot_white,
    output logic               border_white,
    output logic               border_red,
    output logic               turn_over,
    output logic               load_pos,
    output logic [COORD_W-1:0] red_x,
    output logic [COORD_W-1:0] red_y,
    output logic [COORD_W-1:0] white_x,
    output logic [COORD_W-1:0] white_y,
    output logic [HOLE_W-1:0]  target_hole,
    output logic [COORD_W-1:0] target_x,
    output logic [COORD_W-1:0] target_y,
    output logic [LEVEL_W-1:0] level,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    level_entry_t       entry_q, entry_d;
    logic               load_pos_q, load_pos_d;
    logic               turn_over_q, turn_over_d;
    logic               frame_hit_q, frame_hit_d;
    logic               single_q, single_d;
    logic [HOLE_W-1:0]  red_idx_q, red_idx_d;
    logic [HOLE_W-1:0]  low_idx;
    logic               any_hole;
    logic               red_raw;
    logic               red_armed;
    logic               turn_end;
    logic               score_inc;
    logic               score_dec;
    logic               unused_wr_armed;
    logic               unused_pw_armed;

    assign any_hole     = |dr_hole;
    assign red_raw      = dr_red & any_hole;
    assign border_white = dr_white & dr_border;
    assign border_red   = dr_red & dr_border;
    assign collision    = (dr_white & dr_red) | (dr_red & any_hole)
                        | (dr_white & any_hole) | border_white
                        | border_red;

    event_holdoff #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) u_hold_wr (
        .clk            (clk),
        .reset          (reset),
        .raw            (dr_white & dr_red),
        .start_of_frame (start_of_frame),
        .pulse          (hit_white_red),
        .armed          (unused_wr_armed)
    );

    event_holdoff #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) u_hold_red (
        .clk            (clk),
        .reset          (reset),
        .raw            (red_raw),
        .start_of_frame (start_of_frame),
        .pulse          (pot_red),
        .armed          (red_armed)
    );

    event_holdoff #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) u_hold_pw (
        .clk            (clk),
        .reset          (reset),
        .raw            (dr_white & any_hole),
        .start_of_frame (start_of_frame),
        .pulse          (pot_white),
        .armed          (unused_pw_armed)
    );

    always_comb begin
        low_idx = '0;
        for (int i = int'(N_HOLES) - 1; i >= 0; i--) begin
            if (dr_hole[i]) low_idx = HOLE_W'(i);
        end
    end

    // Setting the frame flag takes priority over a frame-start clear.
    always_comb begin
        single_d    = collision && !frame_hit_q;
        frame_hit_d = frame_hit_q;
        if (single_d) frame_hit_d = 1'b1;
        else if (start_of_frame) frame_hit_d = 1'b0;
        red_idx_d = red_idx_q;
        if (red_raw && red_armed) red_idx_d = low_idx;
    end

    assign score_inc = pot_red
        && (red_idx_q == HOLE_W'(entry_q.target_hole));
    assign score_dec = pot_white;
    assign turn_end  = pot_red || pot_white
        || (white_started && white_stopped && red_stopped);

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        score_d     = score_q;
        entry_d     = entry_q;
        load_pos_d  = 1'b0;
        turn_over_d = 1'b0;
        unique case (state_q)
            S_INIT: state_d = S_LOAD;
            S_LOAD: begin
                entry_d    = LEVEL_TABLE[level_q - LEVEL_W'(1)];
                load_pos_d = 1'b1;
                state_d    = S_ARM;
            end
            S_ARM: if (!white_started) state_d = S_PLAY;
            S_PLAY: begin
                if (score_inc && !score_dec && score_q != SCORE_MAX)
                    score_d = score_q + SCORE_W'(1);
                else if (score_dec && !score_inc && score_q != '0)
                    score_d = score_q - SCORE_W'(1);
                if (turn_end) begin
                    turn_over_d = 1'b1;
                    if (level_q < LEVEL_W'(N_LEVELS)) begin
                        level_d = level_q + LEVEL_W'(1);
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_OVER;
                    end
                end
            end
            S_OVER: begin
                if (restart) begin
                    level_d = LEVEL_W'(1);
                    score_d = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            level_q     <= LEVEL_W'(1);
            score_q     <= '0;
            entry_q     <= LEVEL_TABLE[0];
            load_pos_q  <= 1'b0;
            turn_over_q <= 1'b0;
            frame_hit_q <= 1'b0;
            single_q    <= 1'b0;
            red_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            score_q     <= score_d;
            entry_q     <= entry_d;
            load_pos_q  <= load_pos_d;
            turn_over_q <= turn_over_d;
            frame_hit_q <= frame_hit_d;
            single_q    <= single_d;
            red_idx_q   <= red_idx_d;
        end
    end

    assign single_hit_pulse = single_q;
    assign turn_over        = turn_over_q;
    assign load_pos         = load_pos_q;
    assign red_x            = COORD_W'(entry_q.red_x);
    assign red_y            = COORD_W'(entry_q.red_y);
    assign white_x          = COORD_W'(entry_q.white_x);
    assign white_y          = COORD_W'(entry_q.white_y);
    assign target_hole      = HOLE_W'(entry_q.target_hole);
    assign target_x         = COORD_W'(HOLE_X[entry_q.target_hole]);
    assign target_y         = COORD_W'(HOLE_Y[entry_q.target_hole]);
    assign level            = level_q;
    assign score            = score_q;
    assign game_over        = (state_q == S_OVER);

endmodule

// File: tb/tb_pool_turn_controller.sv
// Self-checking bench for pool_turn_controller: directed scenarios
// plus randomized play against a behavioural game model.
module tb_pool_turn_controller;
    import pool_game_pkg::*;

    localparam int NH   = 6;
    localparam int NL   = 10;
    localparam int CW   = 11;
    localparam int SW   = 3;
    localparam int HF   = 4;
    localparam int HW   = 3;
    localparam int LW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_of_frame = 1'b0;
    logic          dr_white = 1'b0;
    logic          dr_red = 1'b0;
    logic [NH-1:0] dr_hole = '0;
    logic          dr_border = 1'b0;
    logic          white_stopped = 1'b0;
    logic          red_stopped = 1'b0;
    logic          white_started = 1'b0;
    logic          restart = 1'b0;
    logic          collision, single_hit_pulse, hit_white_red;
    logic          pot_red, pot_white, border_white, border_red;
    logic          turn_over, load_pos, game_over;
    logic [CW-1:0] red_x, red_y, white_x, white_y, target_x, target_y;
    logic [HW-1:0] target_hole;
    logic [LW-1:0] level;
    logic [SW-1:0] score;

    int checks = 0;
    int failures = 0;

    pool_turn_controller #(
        .N_HOLES(NH), .N_LEVELS(NL), .COORD_W(CW),
        .SCORE_W(SW), .HOLDOFF_FRAMES(HF)
    ) dut (
        .clk(clk), .reset(reset), .start_of_frame(start_of_frame),
        .dr_white(dr_white), .dr_red(dr_red), .dr_hole(dr_hole),
        .dr_border(dr_border), .white_stopped(white_stopped),
        .red_stopped(red_stopped), .white_started(white_started),
        .restart(restart), .collision(collision),
        .single_hit_pulse(single_hit_pulse),
        .hit_white_red(hit_white_red), .pot_red(pot_red),
        .pot_white(pot_white), .border_white(border_white),
        .border_red(border_red), .turn_over(turn_over),
        .load_pos(load_pos), .red_x(red_x), .red_y(red_y),
        .white_x(white_x), .white_y(white_y),
        .target_hole(target_hole), .target_x(target_x),
        .target_y(target_y), .level(level), .score(score),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Game model: phase 0 init, 1 load, 2 arm, 3 play, 4 over.
    int           m_ph, m_level, m_score, m_red_idx;
    int           m_hold [3];
    bit           m_flag, m_single, m_hwr, m_pr, m_pw, m_turn, m_load;
    level_entry_t m_ent;

    task automatic model_reset();
        m_ph = 0; m_level = 1; m_score = 0; m_red_idx = 0;
        for (int e = 0; e < 3; e++) m_hold[e] = 0;
        m_flag = 0; m_single = 0; m_hwr = 0; m_pr = 0; m_pw = 0;
        m_turn = 0; m_load = 0; m_ent = LEVEL_TABLE[0];
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic tick();
        bit hole_any, coll, n_single, n_flag, n_turn, n_load;
        bit raw [3];
        bit fire [3];
        int nh [3];
        int n_idx, n_ph, n_level, n_score, delta, tgt;
        level_entry_t n_ent;
        hole_any = |dr_hole;
        coll = (dr_white && dr_red)
            || ((dr_white || dr_red) && (hole_any || dr_border));
        n_single = coll && !m_flag;
        n_flag = n_single ? 1'b1 : (start_of_frame ? 1'b0 : m_flag);
        raw[0] = dr_white && dr_red;
        raw[1] = dr_red && hole_any;
        raw[2] = dr_white && hole_any;
        for (int e = 0; e < 3; e++) begin
            fire[e] = raw[e] && m_hold[e] == 0;
            if (fire[e]) nh[e] = HF;
            else if (start_of_frame && m_hold[e] > 0) nh[e] = m_hold[e] - 1;
            else nh[e] = m_hold[e];
        end
        n_idx = m_red_idx;
        if (fire[1])
            for (int i = NH - 1; i >= 0; i--) if (dr_hole[i]) n_idx = i;
        n_ph = m_ph; n_level = m_level; n_score = m_score;
        n_turn = 0; n_load = 0; n_ent = m_ent;
        case (m_ph)
            0: n_ph = 1;
            1: begin
                n_ent = LEVEL_TABLE[m_level-1]; n_load = 1; n_ph = 2;
            end
            2: if (!white_started) n_ph = 3;
            3: begin
                tgt = int'(LEVEL_TABLE[m_level-1].target_hole);
                delta = 0;
                if (m_pr && m_red_idx == tgt) delta++;
                if (m_pw) delta--;
                n_score = m_score + delta;
                if (n_score < 0) n_score = 0;
                if (n_score > SMAX) n_score = SMAX;
                if (m_pr || m_pw
                    || (white_started && white_stopped && red_stopped)) begin
                    n_turn = 1;
                    if (m_level < NL) begin
                        n_level = m_level + 1; n_ph = 1;
                    end else n_ph = 4;
                end
            end
            default: if (restart) begin
                n_level = 1; n_score = 0; n_ph = 1;
            end
        endcase
        @(posedge clk);
        m_flag = n_flag; m_single = n_single;
        m_hwr = fire[0]; m_pr = fire[1]; m_pw = fire[2];
        for (int e = 0; e < 3; e++) m_hold[e] = nh[e];
        m_red_idx = n_idx; m_ph = n_ph; m_level = n_level;
        m_score = n_score; m_turn = n_turn; m_load = n_load; m_ent = n_ent;
        #1;
    endtask

    task automatic clear_inputs();
        start_of_frame = 0; dr_white = 0; dr_red = 0; dr_hole = '0;
        dr_border = 0; white_stopped = 0; red_stopped = 0;
        white_started = 0; restart = 0;
    endtask

    task automatic goto_play();
        int n = 0;
        while (m_ph != 3 && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            failures++;
            $display("FAIL goto_play: timeout phase=%0d", m_ph);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            start_of_frame = 1; tick();
            start_of_frame = 0; tick(); tick(); tick();
        end
    endtask

    task automatic pot_target();
        dr_red = 1;
        dr_hole = NH'(1) << LEVEL_TABLE[m_level-1].target_hole;
        tick();
        dr_red = 0; dr_hole = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1; model_reset();
        #2;
        checks++;
        if (level !== 4'd1 || score !== 3'd0 || game_over !== 1'b0
            || load_pos !== 1'b0 || turn_over !== 1'b0 || pot_red !== 1'b0)
            begin
            failures++;
            $display("FAIL reset_vals: lvl=%0d sc=%0d go=%b lp=%b want 1 0 0 0",
                     level, score, game_over, load_pos);
        end
        @(posedge clk); #1; reset = 1'b0;
        tick();
        checks++;
        if (load_pos !== 1'b0) begin
            failures++;
            $display("FAIL load_pos_early: got %b want 0", load_pos);
        end
        tick();
        checks++;
        if (load_pos !== 1'b1 || red_x !== LEVEL_TABLE[0].red_x
            || red_y !== LEVEL_TABLE[0].red_y
            || white_x !== LEVEL_TABLE[0].white_x
            || white_y !== LEVEL_TABLE[0].white_y) begin
            failures++;
            $display("FAIL load_pos_l1: lp=%b rx=%0d wx=%0d want 1 %0d %0d",
                     load_pos, red_x, white_x, LEVEL_TABLE[0].red_x,
                     LEVEL_TABLE[0].white_x);
        end
    endtask

    task automatic test_pot_red();
        goto_play();
        pot_target();
        checks++;
        if (pot_red !== 1'b1) begin
            failures++;
            $display("FAIL pot_red_pulse: got %b want 1", pot_red);
        end
        tick();
        checks++;
        if (score !== 3'd1 || turn_over !== 1'b1 || level !== 4'd2) begin
            failures++;
            $display("FAIL pot_red_turn: sc=%0d to=%b lvl=%0d want 1 1 2",
                     score, turn_over, level);
        end
        tick();
        checks++;
        if (load_pos !== 1'b1 || red_x !== LEVEL_TABLE[1].red_x
            || target_hole !== LEVEL_TABLE[1].target_hole
            || target_x !== HOLE_X[LEVEL_TABLE[1].target_hole]
            || target_y !== HOLE_Y[LEVEL_TABLE[1].target_hole]) begin
            failures++;
            $display("FAIL load_l2: lp=%b rx=%0d th=%0d tx=%0d",
                     load_pos, red_x, target_hole, target_x);
        end
    endtask

    task automatic test_pot_white_holdoff();
        int cnt = 0;
        clear_inputs(); apply_reset(); goto_play();
        dr_white = 1; dr_hole = NH'(1);
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 8; c++) begin
                start_of_frame = (c == 0);
                tick();
                if (pot_white === 1'b1) cnt++;
            end
        clear_inputs(); tick();
        checks++;
        if (cnt != 1) begin
            failures++;
            $display("FAIL pw_holdoff: pulses=%0d want 1", cnt);
        end
        checks++;
        if (score !== 3'd0 || level !== 4'd2) begin
            failures++;
            $display("FAIL pw_floor: sc=%0d lvl=%0d want 0 2", score, level);
        end
    endtask

    task automatic test_single_hit();
        bit seq_c [10] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 0};
        bit seq_s [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int cnt = 0;
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            dr_white = seq_c[i]; dr_border = seq_c[i];
            start_of_frame = seq_s[i];
            #1;
            if (i == 1) begin
                checks++;
                if (collision !== 1'b1 || border_white !== 1'b1
                    || border_red !== 1'b0) begin
                    failures++;
                    $display("FAIL border_lvl: col=%b bw=%b br=%b want 1 1 0",
                             collision, border_white, border_red);
                end
            end
            tick();
            if (single_hit_pulse === 1'b1) cnt++;
        end
        clear_inputs();
        checks++;
        if (cnt != 2) begin
            failures++;
            $display("FAIL single_hit: pulses=%0d want 2", cnt);
        end
    endtask

    task automatic test_score_saturate();
        int n;
        clear_inputs(); apply_reset();
        for (int k = 0; k < SMAX + 1; k++) begin
            goto_play(); frames(HF + 1); pot_target();
            tick(); tick();
            if (k >= SMAX - 1) begin
                checks++;
                if (score !== 3'(SMAX)) begin
                    failures++;
                    $display("FAIL score_sat%0d: got %0d want %0d",
                             k, score, SMAX);
                end
            end
        end
        white_started = 1; n = 0;
        while (m_ph != 2 && n < 20) begin tick(); n++; end
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if (level !== 4'd1 || score !== 3'd0 || load_pos !== 1'b0
            || turn_over !== 1'b0 || game_over !== 1'b0
            || red_x !== LEVEL_TABLE[0].red_x
            || white_y !== LEVEL_TABLE[0].white_y || n >= 20) begin
            failures++;
            $display("FAIL arm_reset: lvl=%0d sc=%0d rx=%0d want 1 0 %0d",
                     level, score, red_x, LEVEL_TABLE[0].red_x);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0; white_started = 0;
    endtask

    task automatic test_game_over();
        int n = 0;
        clear_inputs(); apply_reset();
        while (m_ph != 4 && n < 400) begin
            if (m_ph == 3) begin
                white_started = 1; white_stopped = 1; red_stopped = 1;
                tick();
                white_started = 0; white_stopped = 0; red_stopped = 0;
            end else tick();
            n++;
        end
        checks++;
        if (game_over !== 1'b1 || level !== 4'd10 || turn_over !== 1'b1) begin
            failures++;
            $display("FAIL game_over: go=%b lvl=%0d to=%b want 1 10 1",
                     game_over, level, turn_over);
        end
        pot_target();
        white_started = 1; white_stopped = 1; red_stopped = 1;
        tick(); tick();
        clear_inputs();
        checks++;
        if (score !== 3'd0 || game_over !== 1'b1 || level !== 4'd10) begin
            failures++;
            $display("FAIL over_ignore: sc=%0d go=%b lvl=%0d want 0 1 10",
                     score, game_over, level);
        end
        restart = 1; tick(); restart = 0;
        checks++;
        if (level !== 4'd1 || score !== 3'd0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL restart: lvl=%0d sc=%0d go=%b want 1 0 0",
                     level, score, game_over);
        end
        tick();
        checks++;
        if (load_pos !== 1'b1 || red_x !== LEVEL_TABLE[0].red_x) begin
            failures++;
            $display("FAIL restart_load: lp=%b rx=%0d want 1 %0d",
                     load_pos, red_x, LEVEL_TABLE[0].red_x);
        end
    endtask

    task automatic test_random();
        bit ec;
        clear_inputs(); apply_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) apply_reset();
            start_of_frame = ($urandom_range(0, 7) == 0);
            dr_white = ($urandom_range(0, 3) == 0);
            dr_red = ($urandom_range(0, 3) == 0);
            dr_border = ($urandom_range(0, 5) == 0);
            dr_hole = ($urandom_range(0, 4) == 0)
                ? NH'($urandom_range(1, 63)) : '0;
            white_started = ($urandom_range(0, 3) == 0);
            white_stopped = 1'($urandom_range(0, 1));
            red_stopped = 1'($urandom_range(0, 1));
            restart = ($urandom_range(0, 15) == 0);
            #1;
            ec = (dr_white && dr_red)
                || ((dr_white || dr_red) && ((|dr_hole) || dr_border));
            checks++;
            if (collision !== ec
                || border_white !== (dr_white && dr_border)
                || border_red !== (dr_red && dr_border)
                || single_hit_pulse !== m_single
                || hit_white_red !== m_hwr || pot_red !== m_pr
                || pot_white !== m_pw || turn_over !== m_turn
                || load_pos !== m_load || game_over !== (m_ph == 4)
                || level !== 4'(m_level) || score !== 3'(m_score)
                || red_x !== m_ent.red_x || red_y !== m_ent.red_y
                || white_x !== m_ent.white_x || white_y !== m_ent.white_y
                || target_hole !== m_ent.target_hole
                || target_x !== HOLE_X[m_ent.target_hole]
                || target_y !== HOLE_Y[m_ent.target_hole]) begin
                failures++;
                $display("FAIL rand%0d: lvl=%0d/%0d sc=%0d/%0d pr=%b/%b pw=%b/%b to=%b/%b sh=%b/%b",
                         i, level, m_level, score, m_score, pot_red, m_pr,
                         pot_white, m_pw, turn_over, m_turn,
                         single_hit_pulse, m_single);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_pot_red();
        test_pot_white_holdoff();
        test_single_hit();
        test_score_saturate();
        test_game_over();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_turn_controller.md
Name: pool_turn_controller

Overview:
- Parametrised successor of the single-table game controller.
- Turns raw per-pixel drawing requests (white ball, red ball, N pockets, border) into collision levels and debounced one-cycle event pulses.
- Runs the level/turn FSM, keeps a saturating score and broadcasts per-level ball start positions and target pocket from a package level table.
- Sits between the object drawers/ball physics blocks and the score/level display.

Parameters:
- N_HOLES, 6, number of pockets; width of dr_hole.
- N_LEVELS, 10, levels before game over (1..N_LEVELS).
- COORD_W, 11, pixel coordinate width.
- SCORE_W, 4, score width; saturates at 2^SCORE_W-1.
- HOLDOFF_FRAMES, 4, frames an event stays masked after firing.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_of_frame  in  1  one-cycle pulse per frame
- dr_white  in  1  white ball drawing
- dr_red  in  1  red ball drawing
- dr_hole  in  N_HOLES  per-pocket drawing
- dr_border  in  1  border drawing
- white_stopped  in  1  white ball at rest
- red_stopped  in  1  red ball at rest
- white_started  in  1  white ball has been struck this turn
- restart  in  1  start a new game from game over
- collision  out  1  any overlap, combinational
- single_hit_pulse  out  1  first collision of each frame
- hit_white_red  out  1  debounced pulse
- pot_red  out  1  debounced pulse, red in any pocket
- pot_white  out  1  debounced pulse, white in any pocket
- border_white, border_red  out  1 each  combinational overlap levels
- turn_over  out  1  one-cycle pulse at turn end
- load_pos  out  1  one-cycle pulse, positions valid
- red_x, red_y, white_x, white_y  out  COORD_W  registered start positions
- target_hole  out  $clog2(N_HOLES)  current target pocket
- target_x, target_y  out  COORD_W  target marker location
- level  out  $clog2(N_LEVELS+1)  1-based level
- score  out  SCORE_W  current score
- game_over  out  1  high in S_OVER

Behaviour:
- Reset values: state S_INIT, level=1, score=0, all pulses 0, positions/target = LEVEL_TABLE[0], game_over=0.
- collision = (white&red) | (red&|hole) | (white&|hole) | (white&border) | (red&border).
- single_hit_pulse: 1 cycle after the first collision cycle while frame flag=0; sets flag. start_of_frame clears flag. If collision, start_of_frame and flag=0 coincide, the pulse fires and set wins.
- Debounce, one event_holdoff per event (white-red, red-pocket, white-pocket):
  - The raw condition with holdoff count=0 gives a registered 1-cycle pulse (latency 1).
  - The count then loads HOLDOFF_FRAMES and decrements on each start_of_frame.
  - The event re-arms at 0.
- Red pocket index: lowest set bit of dr_hole, captured with the pulse.
- Score:
  - score_next = clamp(score + inc - dec, 0, max).
  - inc = pot_red with captured index == target_hole.
  - dec = pot_white.
  - Both in the same cycle: unchanged.
  - Updates in S_PLAY only.
- FSM states S_INIT, S_LOAD, S_ARM, S_PLAY, S_OVER:
  - S_INIT -> S_LOAD.
  - S_LOAD: registers LEVEL_TABLE[level-1] into outputs, load_pos=1 for this cycle, -> S_ARM.
  - S_ARM waits for white_started==0, then -> S_PLAY. This prevents instant retrigger.
  - Turn end in S_PLAY is pot_red | pot_white | (white_started & white_stopped & red_stopped).
  - On turn end, turn_over=1 for one cycle. If level<N_LEVELS, level++ and -> S_LOAD; else -> S_OVER.
  - S_OVER: game_over=1, inputs ignored. restart gives level=1, score=0, -> S_LOAD.
  - restart is ignored outside S_OVER.
- Scoring and turn end in the same cycle: the score update uses the current level's target before level increments.
- Debounce counters keep running across turns. Reset mid-game returns to the reset values immediately.

Decomposition:
- Package pool_game_pkg holds:
  - state enum;
  - level_entry_t struct {red_x, red_y, white_x, white_y, target_hole};
  - HOLE_X/HOLE_Y constant arrays;
  - LEVEL_TABLE[N_LEVELS] constant.
- target_x/y come from HOLE_X/Y[target_hole].
- Sub-module event_holdoff (params HOLDOFF_FRAMES): inputs raw, start_of_frame; output pulse, armed.

Test Plan:
- Reset released -> load_pos pulse 2 cycles later; red_x/y, white_x/y match LEVEL_TABLE[0]; level=1; score=0.
- dr_red high with dr_hole=target bit, in S_PLAY -> pot_red 1 cycle; score 0->1; turn_over pulse; level 2; load_pos follows.
- dr_white & dr_hole[0] held 3 frames with score=0, HOLDOFF_FRAMES=4 -> one pot_white only; score stays 0 (floor).
- Two collisions in one frame, a third after start_of_frame -> exactly two single_hit_pulse.
- white_started=1, then both stopped, at level 10 -> turn_over, game_over=1; restart -> level=1, score=0, load_pos.
- score=15, red into target -> score stays 15. Assert reset during S_ARM -> outputs at reset values.
